// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: scalar aliases, FSM state and the
// {valid, pc, raw_instr} bundle handed to the D pipeline register.
package fetch_unit_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef logic        u1;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold
  } fetch_state_t;

  typedef struct packed {
    u1  valid;
    u64 pc;
    u32 raw_instr;
  } fetch_data_t;

  localparam u64 PcStep = 64'd4;

  // Sequential PC; wraps modulo 2^64.
  function automatic u64 pc_next(input u64 pc);
    return pc + PcStep;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Output slot for the fetch stage plus a one-entry skid register that holds a
// returned instruction while decode is stalled.
module fetch_buf
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic        push_from_skid,
  input  u64          push_pc,
  input  u32          push_instr,
  input  logic        skid_we,
  input  logic        flush,
  input  logic        stall,
  output logic        full,
  output fetch_data_t slot
);

  fetch_data_t slot_q, slot_d;
  u32          skid_q, skid_d;

  always_comb begin
    slot_d = slot_q;
    skid_d = skid_q;
    if (skid_we) begin
      skid_d = push_instr;
    end
    // Flush wins over both refill and consumption: the slot is wrong-path.
    if (flush) begin
      slot_d.valid = 1'b0;
    end else if (push) begin
      slot_d.valid     = 1'b1;
      slot_d.pc        = push_pc;
      slot_d.raw_instr = push_from_skid ? skid_q : push_instr;
    end else if (!stall) begin
      slot_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_q <= '0;
      skid_q <= '0;
    end else begin
      slot_q <= slot_d;
      skid_q <= skid_d;
    end
  end

  assign full = slot_q.valid && stall;
  assign slot = slot_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding instruction reads,
// drops wrong-path responses after a redirect and feeds decode through fetch_buf.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  fetch_state_t state_q, state_d;
  u64           pc_q, pc_d;
  u64           target_q, target_d;
  logic         kill_q, kill_d;

  logic         push, push_from_skid, skid_we, buf_full, deliver;
  fetch_data_t  slot;

  assign ireq_valid = (state_q == StReq);
  assign ireq_addr  = pc_q;

  // A response is only meaningful once its request has been accepted.
  assign deliver = ((state_q == StReq) && iresp_addr_ok && iresp_data_ok) ||
                   ((state_q == StWait) && iresp_data_ok);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    target_d       = target_q;
    kill_d         = kill_q;
    push           = 1'b0;
    push_from_skid = 1'b0;
    skid_we        = 1'b0;

    unique case (state_q)
      StReq, StWait: begin
        if (deliver) begin
          if (kill_q || redirect_valid) begin
            pc_d    = redirect_valid ? redirect_pc : target_q;
            kill_d  = 1'b0;
            state_d = StReq;
          end else if (!buf_full) begin
            push    = 1'b1;
            pc_d    = pc_next(pc_q);
            state_d = StReq;
          end else begin
            skid_we = 1'b1;
            state_d = StHold;
          end
        end else begin
          if (state_q == StReq && iresp_addr_ok) begin
            state_d = StWait;
          end
          // The request stays on the bus; its response is dropped later.
          if (redirect_valid) begin
            kill_d   = 1'b1;
            target_d = redirect_pc;
          end
        end
      end
      StHold: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = StReq;
        end else if (!stall) begin
          push           = 1'b1;
          push_from_skid = 1'b1;
          pc_d           = pc_next(pc_q);
          state_d        = StReq;
        end
      end
      default: begin
        state_d = StReq;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StReq;
      pc_q     <= PC_RESET;
      target_q <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      kill_q   <= kill_d;
    end
  end

  fetch_buf u_fetch_buf (
    .clk            (clk),
    .resetn         (resetn),
    .push           (push),
    .push_from_skid (push_from_skid),
    .push_pc        (pc_q),
    .push_instr     (iresp_data),
    .skid_we        (skid_we),
    .flush          (redirect_valid),
    .stall          (stall),
    .full           (buf_full),
    .slot           (slot)
  );

  assign out_valid = slot.valid;
  assign out_pc    = slot.pc;
  assign out_instr = slot.raw_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays the instruction bus cycle by cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_RESET(64'h8000_0000)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  function automatic logic [31:0] word_of(input logic [63:0] addr);
    return addr[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch with `delay` cycles of addr_ok back-pressure; assumes stall=0.
  task automatic fetch_one(input logic [63:0] exp_pc, input int delay);
    check_eq("req_valid", {63'd0, ireq_valid}, 64'd1);
    check_eq("req_addr", ireq_addr, exp_pc);
    for (int i = 0; i < delay; i++) begin
      iresp_addr_ok = 1'b0;
      tick();
      check_eq("addr_hold_valid", {63'd0, ireq_valid}, 64'd1);
      check_eq("addr_hold", ireq_addr, exp_pc);
    end
    iresp_addr_ok = 1'b1;
    tick();
    iresp_addr_ok = 1'b0;
    check_eq("wait_no_req", {63'd0, ireq_valid}, 64'd0);
    check_eq("slot_empty", {63'd0, out_valid}, 64'd0);
    iresp_data_ok = 1'b1;
    iresp_data    = word_of(exp_pc);
    tick();
    iresp_data_ok = 1'b0;
    check_eq("out_valid", {63'd0, out_valid}, 64'd1);
    check_eq("out_pc", out_pc, exp_pc);
    check_eq("out_instr", {32'd0, out_instr}, {32'd0, word_of(exp_pc)});
    check_eq("next_addr", ireq_addr, exp_pc + 64'd4);
  endtask

  initial begin
    resetn         = 1'b0;
    iresp_addr_ok  = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();
    check_eq("rst_req_valid", {63'd0, ireq_valid}, 64'd1);
    check_eq("rst_req_addr", ireq_addr, 64'h8000_0000);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_out_pc", out_pc, 64'd0);
    check_eq("rst_out_instr", {32'd0, out_instr}, 64'd0);
    resetn = 1'b1;
    tick();

    // Zero-wait memory, then a delayed accept.
    fetch_one(64'h8000_0000, 0);
    fetch_one(64'h8000_0004, 0);
    fetch_one(64'h8000_0008, 0);
    fetch_one(64'h8000_000C, 3);

    // Stall while a response returns: slot keeps 000C, skid takes 0010.
    stall         = 1'b1;
    iresp_addr_ok = 1'b1;
    tick();
    iresp_addr_ok = 1'b0;
    check_eq("stall_slot_kept", out_pc, 64'h8000_000C);
    iresp_data_ok = 1'b1;
    iresp_data    = word_of(64'h8000_0010);
    tick();
    iresp_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("hold_no_req", {63'd0, ireq_valid}, 64'd0);
      check_eq("hold_slot_valid", {63'd0, out_valid}, 64'd1);
      check_eq("hold_slot_pc", out_pc, 64'h8000_000C);
      tick();
    end
    stall = 1'b0;
    tick();
    check_eq("skid_valid", {63'd0, out_valid}, 64'd1);
    check_eq("skid_pc", out_pc, 64'h8000_0010);
    check_eq("skid_instr", {32'd0, out_instr}, {32'd0, word_of(64'h8000_0010)});
    fetch_one(64'h8000_0014, 0);

    // Redirect while waiting for data.
    stall         = 1'b1;
    iresp_addr_ok = 1'b1;
    tick();
    iresp_addr_ok  = 1'b0;
    check_eq("pre_redir_valid", {63'd0, out_valid}, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    check_eq("redir_clears_slot", {63'd0, out_valid}, 64'd0);
    check_eq("redir_wait_no_req", {63'd0, ireq_valid}, 64'd0);
    iresp_data_ok = 1'b1;
    iresp_data    = word_of(64'h8000_0018);
    tick();
    iresp_data_ok = 1'b0;
    check_eq("redir_drop", {63'd0, out_valid}, 64'd0);
    fetch_one(64'h8000_0100, 0);

    // Two redirects before the request is accepted; the latest wins.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    tick();
    check_eq("kill_req_kept", ireq_addr, 64'h8000_0104);
    check_eq("kill_slot_clear", {63'd0, out_valid}, 64'd0);
    redirect_pc = 64'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    check_eq("kill_req_kept2", ireq_addr, 64'h8000_0104);
    iresp_addr_ok = 1'b1;
    tick();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = word_of(64'h8000_0104);
    tick();
    iresp_data_ok = 1'b0;
    check_eq("kill_drop", {63'd0, out_valid}, 64'd0);
    fetch_one(64'h8000_0300, 0);

    // Redirect from HOLD to the top of the address space.
    stall         = 1'b1;
    iresp_addr_ok = 1'b1;
    tick();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = word_of(64'h8000_0304);
    tick();
    iresp_data_ok = 1'b0;
    check_eq("hold2_no_req", {63'd0, ireq_valid}, 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    check_eq("hold_redir_slot", {63'd0, out_valid}, 64'd0);
    fetch_one(64'hFFFF_FFFF_FFFF_FFFC, 0);
    check_eq("wrap_addr", ireq_addr, 64'd0);
    fetch_one(64'd0, 0);

    // data_ok without addr_ok in REQ is ignored.
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hDEAD_BEEF;
    tick();
    iresp_data_ok = 1'b0;
    check_eq("stray_data_valid", {63'd0, out_valid}, 64'd0);
    check_eq("stray_data_req", ireq_addr, 64'd4);

    // Asynchronous reset mid-request.
    iresp_addr_ok = 1'b1;
    tick();
    iresp_addr_ok = 1'b0;
    resetn        = 1'b0;
    #1;
    check_eq("async_rst_valid", {63'd0, ireq_valid}, 64'd1);
    check_eq("async_rst_addr", ireq_addr, 64'h8000_0000);
    tick();
    resetn = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage pipeline: owns the PC, issues one-outstanding instruction-bus reads, and presents `{valid, pc, raw_instr}` as `dataF_nxt` to the D pipeline register. It absorbs branch redirects from execute and stalls from the hazard unit. It drops wrong-path responses and buffers one returned instruction while decode is stalled.

## Interface
- `PC_RESET`, default 64'h8000_0000: first fetch address after reset.
- `clk  in  1`: single clock; all state on rising edge.
- `resetn  in  1`: asynchronous, active-low reset.
- `ireq_valid  out  1`: read request valid.
- `ireq_addr  out  64`: read address; stable while `ireq_valid && !iresp_addr_ok`.
- `iresp_addr_ok  in  1`: request accepted this cycle.
- `iresp_data_ok  in  1`: read data returned this cycle.
- `iresp_data  in  32`: instruction word.
- `stall  in  1`: hazard `stallF`; decode does not take the output this cycle.
- `redirect_valid  in  1`: branch taken in execute.
- `redirect_pc  in  64`: branch target `pcbranch`.
- `out_valid  out  1`: `dataF_nxt.valid`.
- `out_pc  out  64`: `dataF_nxt.pc`.
- `out_instr  out  32`: `dataF_nxt.raw_instr`.

## Operation
- State: `pc_q` (next fetch address), FSM {REQ, WAIT, HOLD}, `kill_q` with `target_q`, output slot (`out_*`), skid slot `skid_instr`.
- REQ: `ireq_valid=1`, `ireq_addr=pc_q`.
  - On `addr_ok` without `data_ok`, go to WAIT.
  - On `addr_ok` and `data_ok` in the same cycle, run the *deliver* step.
  - `data_ok` without `addr_ok` in REQ is ignored.
- WAIT: `ireq_valid=0`. On `data_ok`, run *deliver*.
- Deliver:
  - If `kill_q` or `redirect_valid`, discard the data. Set `pc_q` to the redirect target: current `redirect_pc` takes precedence over `target_q`. Clear `kill_q` and go to REQ.
  - Else if the slot is free (`!out_valid || !stall`), load the slot with `{1, pc_q, data}`, set `pc_q += 4`, and go to REQ.
  - Else store the data in `skid_instr` and go to HOLD.
- HOLD: `ireq_valid=0`. When `stall=0`, the slot is consumed and reloaded with `{1, pc_q, skid_instr}`. `pc_q += 4`, then go to REQ.
- Consumption: the slot empties on any edge with `out_valid && !stall` unless it is refilled on the same edge.
- Redirect, whose effect in every state takes priority over consumption and delivery:
  - `out_valid <= 0`, because the slot holds a wrong-path instruction.
  - In HOLD: discard the skid, `pc_q <= redirect_pc`, go to REQ.
  - In REQ or WAIT: the in-flight request is not withdrawn. Set `kill_q=1` and `target_q=redirect_pc`. A later redirect overwrites `target_q`, so the latest one wins.
- PC arithmetic is modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0. Low address bits pass through unmodified.

## Timing
- Reset values: `ireq_valid=1`, `ireq_addr=PC_RESET`, `out_valid=0`, `out_pc=0`, `out_instr=0`; FSM=REQ, `kill_q=0`.
- Asserting reset mid-operation aborts everything immediately. Any bus response arriving before a new `addr_ok` is ignored.
- Latency: `data_ok` at edge N gives `out_valid=1` from N+1. The next request is visible in the cycle after N.
- Best-case throughput: one instruction per 2 cycles with zero-wait memory.
- All outputs are registered, except that `ireq_valid` and `ireq_addr` are decoded directly from the FSM state and `pc_q`.

## Structure
- `pipes` package:
  - Add `fetch_state_t` enum {REQ, WAIT, HOLD}.
  - Reuse `fetch_data_t` for the output bundle.
  - Reuse `u64`/`u32`/`u1` from `common`.
- Sub-module `fetch_buf`: contains the output slot plus skid register and the stall/flush logic. It exposes `push`, `full`, `flush`, and pop-on-`!stall`.
- The parent module keeps the FSM, `pc_q` and the kill logic.

## Test plan
- Reset, zero-wait memory (`addr_ok` immediate, `data_ok` next cycle): outputs are PCs 8000_0000, 8000_0004, 8000_0008 with matching words, and `out_valid` pulses every 2nd cycle.
- `addr_ok` delayed 3 cycles: `ireq_addr` stays 8000_0000 and does not change until acceptance.
- Hold `stall=1` for 4 cycles while a response returns:
  - The slot holds PC0 and the skid holds PC1 word; no new request is issued.
  - On release, PC1 appears next cycle, then fetching resumes at +8.
- `redirect_valid` with target 8000_0100 while in WAIT:
  - `out_valid` clears.
  - The returning word is dropped.
  - The next `ireq_addr` is 8000_0100 and the first output PC is 8000_0100.
- Two redirects (…0200, then …0300) while in REQ before `addr_ok`: the response is dropped, and the next fetch is at …0300.
- Redirect to FFFF_FFFF_FFFF_FFFC: the output PC sequence is …FFFC, then 0000_0000_0000_0000.
